// File: rtl/egg_countdown_pkg.sv
// Shared types for the egg timer countdown: FSM state encoding and default count width.
// Combinational definitions only; no flow control.
package egg_countdown_pkg;

    localparam int DEFAULT_SIZE = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus an edge flop for a raw button; level after 2 clocks, rise pulse 1 clock wide.
// No backpressure: free-running every clock.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = din;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;

endmodule

// File: rtl/egg_countdown.sv
// Egg timer countdown: loads set_value on a start press, steps count down every TICK_DIV clocks, alarms at zero.
// Start/cancel act 2 clocks after first being sampled; no backpressure, outputs registered.
module egg_countdown
    import egg_countdown_pkg::*;
#(
    parameter int SIZE     = DEFAULT_SIZE,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cancel,
    input  logic [SIZE-1:0] set_value,
    output logic [SIZE-1:0] count,
    output logic            alarm,
    output logic            busy
);

    localparam int PRESC_W = $clog2(TICK_DIV);

    logic start_lvl, start_edge;
    logic cancel_s, cancel_rise;
    logic unused_sync;

    state_e               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [SIZE-1:0]      count_q, count_d;
    logic                 alarm_q, alarm_d;
    logic                 busy_q, busy_d;
    logic                 wrap;

    sync_edge u_start_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (start),
        .level (start_lvl),
        .rise  (start_edge)
    );

    sync_edge u_cancel_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cancel),
        .level (cancel_s),
        .rise  (cancel_rise)
    );

    assign unused_sync = start_lvl ^ cancel_rise;

    assign wrap = (presc_q == PRESC_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;

        unique case (state_q)
            ST_IDLE: begin
                count_d = set_value;
                presc_d = '0;
                if (start_edge && (set_value != '0) && !cancel_s) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Cancel wins over a coincident wrap: count is frozen, no alarm.
                if (cancel_s) begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end else if (wrap) begin
                    presc_d = '0;
                    if (count_q <= SIZE'(1)) begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q - SIZE'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            ST_DONE: begin
                count_d = '0;
                presc_d = '0;
                if (start_edge || cancel_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
                count_d = '0;
            end
        endcase

        alarm_d = (state_d == ST_DONE);
        busy_d  = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            alarm_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            alarm_q <= alarm_d;
            busy_q  <= busy_d;
        end
    end

    assign count = count_q;
    assign alarm = alarm_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_egg_countdown.sv
// Bench for egg_countdown with TICK_DIV=4: per-cycle comparison against an elapsed-time model
// plus hand-computed checkpoints for each scenario.
module tb_egg_countdown;

    localparam int SIZE = 4;
    localparam int TD   = 4;
    localparam int NLOG = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            cancel = 1'b0;
    logic [SIZE-1:0] set_value = 4'd5;
    logic [SIZE-1:0] count;
    logic            alarm;
    logic            busy;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Raw button samples per edge (as seen by the first sync flop) and the model's view.
    bit s_log [NLOG];
    bit c_log [NLOG];
    int cyc     = 3;
    int m_mode  = 0;   // 0 idle, 1 running, 2 alarm
    int m_load  = 0;
    int m_entry = 0;
    int m_count = 0;

    egg_countdown #(.SIZE(SIZE), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cancel    (cancel),
        .set_value (set_value),
        .count     (count),
        .alarm     (alarm),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    // Model: count in a run is load minus whole elapsed tick periods since entry.
    always @(posedge clk) begin : model
        bit se;
        bit cs;
        int el;
        if (cyc < NLOG - 1) cyc++;
        if (rst) begin
            m_mode  = 0;
            m_count = 0;
            for (int i = 0; i < 3; i++) begin
                s_log[cyc - i] = 1'b0;
                c_log[cyc - i] = 1'b0;
            end
        end else begin
            se = s_log[cyc - 2] && !s_log[cyc - 3];
            cs = c_log[cyc - 2];
            case (m_mode)
                0: begin
                    if (se && set_value != 0 && !cs) begin
                        m_mode  = 1;
                        m_load  = int'(set_value);
                        m_entry = cyc;
                        m_count = m_load;
                    end else begin
                        m_count = int'(set_value);
                    end
                end
                1: begin
                    if (cs) begin
                        m_mode = 0;
                    end else begin
                        el      = cyc - m_entry;
                        m_count = m_load - el / TD;
                        if (m_count <= 0) begin
                            m_count = 0;
                            m_mode  = 2;
                        end
                    end
                end
                default: begin
                    m_count = 0;
                    if (se || cs) m_mode = 0;
                end
            endcase
            s_log[cyc] = start;
            c_log[cyc] = cancel;
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_count", int'(count), m_count);
            check("model_alarm", int'(alarm), (m_mode == 2) ? 1 : 0);
            check("model_busy",  int'(busy),  (m_mode == 1) ? 1 : 0);
        end
    end

    initial begin
        // Reset with preset 5
        set_value = 4'd5;
        rst = 1'b1;
        step(1);
        check("rst_count", int'(count), 0);
        check("rst_alarm", int'(alarm), 0);
        check("rst_busy",  int'(busy),  0);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_count", int'(count), 5);
        check("post_rst_busy",  int'(busy),  0);

        // Full run, preset 3
        set_value = 4'd3;
        step(2);
        pulse_start();                 // now just after edge k
        step(1);
        check("run_k1_busy", int'(busy), 0);
        step(1);
        check("run_k2_busy",  int'(busy),  1);
        check("run_k2_count", int'(count), 3);
        step(4);
        check("run_k6_count", int'(count), 2);
        step(3);
        check("run_k9_count", int'(count), 2);
        step(1);
        check("run_k10_count", int'(count), 1);
        step(4);
        check("run_k14_count", int'(count), 0);
        check("run_k14_alarm", int'(alarm), 1);
        check("run_k14_busy",  int'(busy),  0);
        step(3);
        check("done_hold_alarm", int'(alarm), 1);
        pulse_start();                 // edge j
        step(3);
        check("ack_alarm", int'(alarm), 0);
        check("ack_busy",  int'(busy),  0);
        check("ack_count", int'(count), 3);

        // Cancel mid-run, preset 5
        set_value = 4'd5;
        step(2);
        pulse_start();
        step(10);
        check("cancel_pre_count", int'(count), 3);
        cancel = 1'b1;
        step(3);
        check("cancel_busy",  int'(busy),  0);
        check("cancel_alarm", int'(alarm), 0);
        step(1);
        check("cancel_reload", int'(count), 5);
        cancel = 1'b0;
        step(3);

        // Zero preset is ignored
        set_value = 4'd0;
        pulse_start();
        step(5);
        check("zero_busy",  int'(busy),  0);
        check("zero_alarm", int'(alarm), 0);
        check("zero_count", int'(count), 0);

        // Held button: one run, alarm stays while held
        set_value = 4'd2;
        step(1);
        start = 1'b1;
        step(1);
        step(18);
        check("held_alarm", int'(alarm), 1);
        check("held_busy",  int'(busy),  0);
        start = 1'b0;
        step(4);
        check("held_release_alarm", int'(alarm), 1);
        pulse_start();
        step(3);
        check("held_ack_alarm", int'(alarm), 0);
        check("held_ack_count", int'(count), 2);

        // Cancel coincident with the final wrap, preset 2
        pulse_start();
        step(7);
        check("coinc_pre_count", int'(count), 1);
        check("coinc_pre_busy",  int'(busy),  1);
        cancel = 1'b1;
        step(3);
        check("coinc_busy",  int'(busy),  0);
        check("coinc_alarm", int'(alarm), 0);
        check("coinc_count", int'(count), 1);
        step(1);
        check("coinc_reload", int'(count), 2);
        cancel = 1'b0;
        step(3);

        // Reset mid-run, preset 3, at count=2 prescaler=2
        set_value = 4'd3;
        pulse_start();
        step(8);
        check("rstmid_pre_count", int'(count), 2);
        rst = 1'b1;
        step(1);
        check("rstmid_count", int'(count), 0);
        check("rstmid_busy",  int'(busy),  0);
        check("rstmid_alarm", int'(alarm), 0);
        rst = 1'b0;
        step(1);
        check("rstmid_reload", int'(count), 3);
        step(8);
        check("rstmid_idle_busy", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
